// File: rtl/lcd_8080_pkg.sv
// Shared types and defaults for the 8080-style LCD write master.
// No logic; state encoding, timing defaults and byte-lane selection.
// No flow control of its own.
package lcd_8080_pkg;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    IDLE,
    SETUP,
    WR_LO,
    WR_HI
  } state_t;

  localparam int DEF_WR_LOW_CYC   = 2;
  localparam int DEF_WR_HIGH_CYC  = 2;
  localparam int DEF_RST_LOW_CYC  = 500;
  localparam int DEF_RST_WAIT_CYC = 6000000;

  // Wide beats go out high byte first.
  function automatic logic [7:0] first_byte(input logic [15:0] data, input logic wide);
    return wide ? data[15:8] : data[7:0];
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Latency: a load of N gives done after N further cycles.
// No backpressure; the owner decides when to reload.
module lcd_phase_timer #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_8080_wr_ctrl.sv
// Write-only 8080 bus master for the MI-LCD panel plus panel reset sequencer.
// Latency: accept -> 1 setup cycle -> WR_n low/high per byte; streams with no gap.
// Backpressure: s_ready only in IDLE or the last WR_HI cycle with nothing pending.
module lcd_8080_wr_ctrl
  import lcd_8080_pkg::*;
#(
  parameter int WR_LOW_CYC   = DEF_WR_LOW_CYC,
  parameter int WR_HIGH_CYC  = DEF_WR_HIGH_CYC,
  parameter int RST_LOW_CYC  = DEF_RST_LOW_CYC,
  parameter int RST_WAIT_CYC = DEF_RST_WAIT_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_rs,
  input  logic        s_wide,
  input  logic        hw_reset_req,
  output logic        init_done,
  output logic        busy,
  output logic        lcd_rest_n,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [7:0]  lcd_data
);

  localparam int CW = $clog2(max4(WR_LOW_CYC, WR_HIGH_CYC, RST_LOW_CYC, RST_WAIT_CYC) + 1);
  localparam logic [CW-1:0] WR_LO_LD   = CW'(WR_LOW_CYC - 1);
  localparam logic [CW-1:0] WR_HI_LD   = CW'(WR_HIGH_CYC - 1);
  localparam logic [CW-1:0] RST_LO_LD  = CW'(RST_LOW_CYC - 1);
  localparam logic [CW-1:0] RST_WT_LD  = CW'(RST_WAIT_CYC - 1);

  state_t        state;
  logic          rst_pend;
  logic          second_pend;
  logic [7:0]    lo_byte;
  logic          rst_req;
  logic          accept;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;

  // A request arriving this cycle already blocks new beats.
  assign rst_req  = rst_pend | hw_reset_req;
  assign s_ready  = !rst_req &&
                    ((state == IDLE) || (state == WR_HI && tmr_done && !second_pend));
  assign accept   = s_valid && s_ready;
  assign busy     = (state != IDLE);
  assign lcd_rd_n = 1'b1;

  // Timer is preloaded for whichever timed phase the FSM enters next.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = WR_LO_LD;
    case (state)
      RST_LOW: begin
        tmr_load = tmr_done;
        tmr_val  = RST_WT_LD;
      end
      IDLE: begin
        tmr_load = 1'b1;
        tmr_val  = RST_LO_LD;
      end
      SETUP:   tmr_load = 1'b1;
      WR_LO: begin
        tmr_load = tmr_done;
        tmr_val  = WR_HI_LD;
      end
      WR_HI:   tmr_load = tmr_done;
      default: ;
    endcase
  end

  lcd_phase_timer #(.W(CW), .RST_VAL(RST_LO_LD)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RST_LOW;
      lcd_rest_n  <= 1'b0;
      lcd_cs_n    <= 1'b1;
      lcd_wr_n    <= 1'b1;
      lcd_rs      <= 1'b0;
      lcd_data    <= 8'h00;
      init_done   <= 1'b0;
      rst_pend    <= 1'b0;
      second_pend <= 1'b0;
      lo_byte     <= 8'h00;
    end else begin
      if (state == RST_LOW || state == RST_WAIT) rst_pend <= 1'b0;
      else if (hw_reset_req)                     rst_pend <= 1'b1;

      case (state)
        RST_LOW: if (tmr_done) begin
          state      <= RST_WAIT;
          lcd_rest_n <= 1'b1;
        end
        RST_WAIT: if (tmr_done) begin
          state     <= IDLE;
          init_done <= 1'b1;
        end
        IDLE: begin
          if (rst_req) begin
            state      <= RST_LOW;
            lcd_rest_n <= 1'b0;
            init_done  <= 1'b0;
            rst_pend   <= 1'b0;
          end else if (accept) begin
            state       <= SETUP;
            lcd_cs_n    <= 1'b0;
            lcd_rs      <= s_rs;
            lcd_data    <= first_byte(s_data, s_wide);
            lo_byte     <= s_data[7:0];
            second_pend <= s_wide;
          end
        end
        SETUP: begin
          state    <= WR_LO;
          lcd_wr_n <= 1'b0;
        end
        WR_LO: if (tmr_done) begin
          state    <= WR_HI;
          lcd_wr_n <= 1'b1;
        end
        WR_HI: if (tmr_done) begin
          if (second_pend) begin
            state       <= WR_LO;
            lcd_wr_n    <= 1'b0;
            lcd_data    <= lo_byte;
            second_pend <= 1'b0;
          end else if (accept) begin
            state       <= WR_LO;
            lcd_wr_n    <= 1'b0;
            lcd_rs      <= s_rs;
            lcd_data    <= first_byte(s_data, s_wide);
            lo_byte     <= s_data[7:0];
            second_pend <= s_wide;
          end else begin
            state    <= IDLE;
            lcd_cs_n <= 1'b1;
          end
        end
        default: state <= RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_8080_wr_ctrl.sv
// Directed bench for lcd_8080_wr_ctrl with shortened reset timing.
module tb_lcd_8080_wr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_rs;
  logic        s_wide;
  logic        hw_reset_req;
  logic        init_done;
  logic        busy;
  logic        lcd_rest_n;
  logic        lcd_cs_n;
  logic        lcd_rs;
  logic        lcd_wr_n;
  logic        lcd_rd_n;
  logic [7:0]  lcd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic       tr_wr   [32];
  logic       tr_cs   [32];
  logic       tr_rs   [32];
  logic       tr_rdy  [32];
  logic       tr_rst  [32];
  logic       tr_init [32];
  logic [7:0] tr_data [32];

  lcd_8080_wr_ctrl #(
    .WR_LOW_CYC   (2),
    .WR_HIGH_CYC  (2),
    .RST_LOW_CYC  (4),
    .RST_WAIT_CYC (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_rs         (s_rs),
    .s_wide       (s_wide),
    .hw_reset_req (hw_reset_req),
    .init_done    (init_done),
    .busy         (busy),
    .lcd_rest_n   (lcd_rest_n),
    .lcd_cs_n     (lcd_cs_n),
    .lcd_rs       (lcd_rs),
    .lcd_wr_n     (lcd_wr_n),
    .lcd_rd_n     (lcd_rd_n),
    .lcd_data     (lcd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one beat from IDLE and record n cycles starting with the SETUP cycle.
  task automatic send_trace(input logic [15:0] d, input logic rs, input logic wide,
                            input int n, input int hw_at);
    s_valid = 1'b1; s_data = d; s_rs = rs; s_wide = wide;
    @(negedge clk);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      tr_wr[i] = lcd_wr_n;   tr_cs[i] = lcd_cs_n;  tr_rs[i] = lcd_rs;
      tr_rdy[i] = s_ready;   tr_rst[i] = lcd_rest_n; tr_init[i] = init_done;
      tr_data[i] = lcd_data;
      hw_reset_req = (i == hw_at);
      @(negedge clk);
    end
    hw_reset_req = 1'b0;
  endtask

  task automatic wait_ready;
    for (int i = 0; i < 40 && !(init_done && s_ready); i++) @(negedge clk);
    n_cmp++;
    if (!(init_done && s_ready)) begin
      n_fail++;
      $display("FAIL wait_ready: init_done=%b s_ready=%b, required both 1", init_done, s_ready);
    end
  endtask

  task automatic test_reset;
    logic [7:0] pins, stat;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_rs = 1'b0; s_wide = 1'b0; hw_reset_req = 1'b0;
    repeat (3) @(negedge clk);
    pins = {lcd_rest_n, lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, 3'b000};
    stat = {s_ready, init_done, busy, 5'b00000};
    n_cmp++;
    if (pins !== 8'b0111_0000) begin
      n_fail++; $display("FAIL reset_pins: got %b, required %b", pins, 8'b0111_0000);
    end
    n_cmp++;
    if (lcd_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h, required 00", lcd_data);
    end
    n_cmp++;
    if (stat !== 8'b0010_0000) begin
      n_fail++; $display("FAIL reset_status: got %b, required %b", stat, 8'b0010_0000);
    end
    reset = 1'b0;
  endtask

  task automatic test_init_seq;
    int  n_low = 0, n_wait = 0;
    logic rdy_seen = 1'b0;
    for (int i = 0; i < 50 && !lcd_rest_n; i++) begin n_low++; @(negedge clk); end
    for (int i = 0; i < 50 && !init_done; i++) begin
      if (s_ready) rdy_seen = 1'b1;
      n_wait++; @(negedge clk);
    end
    n_cmp++;
    if (n_low != 4) begin n_fail++; $display("FAIL init_rest_low: got %0d cycles, required 4", n_low); end
    n_cmp++;
    if (n_wait != 8) begin n_fail++; $display("FAIL init_wait: got %0d cycles, required 8", n_wait); end
    n_cmp++;
    if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL init_ready_early: s_ready seen high before init_done"); end
    n_cmp++;
    if ({s_ready, busy} !== 2'b10) begin
      n_fail++; $display("FAIL init_idle: s_ready,busy=%b, required 10", {s_ready, busy});
    end
  endtask

  task automatic test_narrow(input logic [7:0] exp_byte);
    logic [5:0] wr_v = '0, cs_v = '0;
    send_trace({8'h00, exp_byte}, 1'b0, 1'b0, 6, -1);
    for (int i = 0; i < 6; i++) begin wr_v = {wr_v[4:0], tr_wr[i]}; cs_v = {cs_v[4:0], tr_cs[i]}; end
    n_cmp++;
    if (wr_v !== 6'b100111) begin n_fail++; $display("FAIL narrow_wr: got %b, required 100111", wr_v); end
    n_cmp++;
    if (cs_v !== 6'b000001) begin n_fail++; $display("FAIL narrow_cs: got %b, required 000001", cs_v); end
    n_cmp++;
    if ({tr_rs[0], tr_data[0]} !== {1'b0, exp_byte}) begin
      n_fail++; $display("FAIL narrow_setup: rs=%b data=%h, required rs=0 data=%h", tr_rs[0], tr_data[0], exp_byte);
    end
    n_cmp++;
    if (tr_data[3] !== exp_byte) begin
      n_fail++; $display("FAIL narrow_hold: data=%h in WR_HI, required %h", tr_data[3], exp_byte);
    end
  endtask

  task automatic test_wide;
    logic [9:0] wr_v = '0, cs_v = '0, rdy_v = '0;
    logic rs_bad = 1'b0;
    send_trace(16'hF800, 1'b1, 1'b1, 10, -1);
    for (int i = 0; i < 10; i++) begin
      wr_v = {wr_v[8:0], tr_wr[i]}; cs_v = {cs_v[8:0], tr_cs[i]}; rdy_v = {rdy_v[8:0], tr_rdy[i]};
      if (i < 9 && tr_rs[i] !== 1'b1) rs_bad = 1'b1;
    end
    n_cmp++;
    if (wr_v !== 10'b1001100111) begin n_fail++; $display("FAIL wide_wr: got %b, required 1001100111", wr_v); end
    n_cmp++;
    if (cs_v !== 10'b0000000001) begin n_fail++; $display("FAIL wide_cs: got %b, required 0000000001", cs_v); end
    n_cmp++;
    if ({tr_data[1], tr_data[4], tr_data[6], tr_data[8]} !== 32'hF8F8_0000) begin
      n_fail++; $display("FAIL wide_bytes: got %h %h %h %h, required f8 f8 00 00",
                         tr_data[1], tr_data[4], tr_data[6], tr_data[8]);
    end
    n_cmp++;
    if (rs_bad !== 1'b0) begin n_fail++; $display("FAIL wide_rs: rs dropped during wide beat, required 1"); end
    n_cmp++;
    if (rdy_v !== 10'b0000000011) begin n_fail++; $display("FAIL wide_ready: got %b, required 0000000011", rdy_v); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] pix [3];
    logic [7:0]  exp_b [6];
    int   rt [6];
    logic [7:0] rd [6];
    int   nr = 0, sent = 0;
    logic prev_wr = 1'b1, hs_pend = 1'b0, started = 1'b0, gap = 1'b0, gap_bad = 1'b0, byte_bad = 1'b0;
    pix[0] = 16'h1234; pix[1] = 16'hABCD; pix[2] = 16'h55AA;
    exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'hAB;
    exp_b[3] = 8'hCD; exp_b[4] = 8'h55; exp_b[5] = 8'hAA;
    s_valid = 1'b1; s_data = pix[0]; s_rs = 1'b1; s_wide = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (!prev_wr && lcd_wr_n && nr < 6) begin rt[nr] = cyc; rd[nr] = lcd_data; nr++; end
      if (started && nr < 6 && lcd_cs_n) gap = 1'b1;
      prev_wr = lcd_wr_n;
      if (hs_pend) begin
        sent++; started = 1'b1; hs_pend = 1'b0;
        if (sent < 3) s_data = pix[sent];
        else s_valid = 1'b0;
      end
      if (s_valid && s_ready) hs_pend = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    n_cmp++;
    if (nr != 6) begin n_fail++; $display("FAIL b2b_count: got %0d rising edges, required 6", nr); end
    for (int i = 1; i < nr; i++) if (rt[i] - rt[i-1] != 4) gap_bad = 1'b1;
    n_cmp++;
    if (gap_bad) begin n_fail++; $display("FAIL b2b_period: rising edge spacing not 4 cycles (first %0d last %0d)", rt[0], rt[nr-1]); end
    for (int i = 0; i < nr; i++) if (rd[i] !== exp_b[i]) byte_bad = 1'b1;
    n_cmp++;
    if (byte_bad) begin
      n_fail++; $display("FAIL b2b_bytes: got %h %h %h %h %h %h, required 12 34 ab cd 55 aa",
                         rd[0], rd[1], rd[2], rd[3], rd[4], rd[5]);
    end
    n_cmp++;
    if (gap) begin n_fail++; $display("FAIL b2b_cs_gap: cs_n went high mid-stream, required continuous low"); end
  endtask

  task automatic test_hw_reset;
    logic [15:0] rst_v = '0;
    logic [8:0]  wr_v = '0;
    int first_init = -1;
    send_trace(16'h07E0, 1'b1, 1'b1, 26, 1);
    for (int i = 0; i < 16; i++) rst_v = {rst_v[14:0], tr_rst[i]};
    for (int i = 0; i < 9; i++) wr_v = {wr_v[7:0], tr_wr[i]};
    for (int i = 10; i < 26; i++) if (first_init < 0 && tr_init[i]) first_init = i;
    n_cmp++;
    if (wr_v !== 9'b100110011) begin n_fail++; $display("FAIL hwrst_wr: got %b, required 100110011", wr_v); end
    n_cmp++;
    if ({tr_data[1], tr_data[6]} !== 16'h07E0) begin
      n_fail++; $display("FAIL hwrst_bytes: got %h %h, required 07 e0", tr_data[1], tr_data[6]);
    end
    n_cmp++;
    if ({tr_rdy[8], tr_rdy[9], tr_cs[9]} !== 3'b001) begin
      n_fail++; $display("FAIL hwrst_ready_cs: ready8,ready9,cs9=%b, required 001", {tr_rdy[8], tr_rdy[9], tr_cs[9]});
    end
    n_cmp++;
    if (rst_v !== 16'b1111111111000011) begin
      n_fail++; $display("FAIL hwrst_rest_n: got %b, required 1111111111000011", rst_v);
    end
    n_cmp++;
    if ({tr_init[9], tr_init[10]} !== 2'b10) begin
      n_fail++; $display("FAIL hwrst_init_drop: init9,init10=%b, required 10", {tr_init[9], tr_init[10]});
    end
    n_cmp++;
    if (first_init != 22) begin n_fail++; $display("FAIL hwrst_init_rise: got index %0d, required 22", first_init); end
  endtask

  task automatic test_async_reset;
    logic [3:0] pins;
    logic [2:0] stat;
    s_valid = 1'b1; s_data = 16'h0011; s_rs = 1'b1; s_wide = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (lcd_wr_n !== 1'b0) begin n_fail++; $display("FAIL arst_pre: wr_n=%b before reset, required 0", lcd_wr_n); end
    #2 reset = 1'b1;
    #1;
    pins = {lcd_wr_n, lcd_cs_n, lcd_rest_n, lcd_rs};
    stat = {s_ready, init_done, busy};
    n_cmp++;
    if (pins !== 4'b1100) begin n_fail++; $display("FAIL arst_pins: wr,cs,rest,rs=%b, required 1100", pins); end
    n_cmp++;
    if (stat !== 3'b001) begin n_fail++; $display("FAIL arst_status: ready,init,busy=%b, required 001", stat); end
    @(negedge clk);
    reset = 1'b0;
    wait_ready();
  endtask

  initial begin
    test_reset();
    test_init_seq();
    test_narrow(8'h2C);
    test_wide();
    test_back_to_back();
    wait_ready();
    test_hw_reset();
    wait_ready();
    test_async_reset();
    test_narrow(8'h3A);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_8080_wr_ctrl.md
Name: lcd_8080_wr_ctrl

Overview:
Write-only Intel-8080 parallel bus master for the 8-bit MI-LCD panel (ILI9341-class), sitting directly upstream of the LCD pins (LCD_CS, LCD_RS_HSD, LCD_WR_SCLK, LCD_RD_VSD, LCD_DATA[7:0]). It consumes a valid/ready stream of command/data beats from the Nios/Avalon side and serialises each into one or two byte writes with programmable WR_n timing. It also generates the panel hardware-reset sequence (LCD_REST_n) at power-up and on software request.

Parameters:
WR_LOW_CYC, 2, clk cycles WR_n held low per byte (>=1)
WR_HIGH_CYC, 2, clk cycles WR_n held high per byte (>=1)
RST_LOW_CYC, 500, cycles LCD_REST_n held low (10 us at 50 MHz)
RST_WAIT_CYC, 6000000, cycles after reset release before first write (120 ms)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
s_valid  in  1  beat valid
s_ready  out  1  beat accepted when s_valid&&s_ready
s_data  in  16  beat payload
s_rs  in  1  0=command, 1=data (drives RS)
s_wide  in  1  1=send s_data[15:8] then [7:0]; 0=send [7:0] only
hw_reset_req  in  1  single-cycle pulse: rerun panel reset sequence
init_done  out  1  high once reset sequence completes
busy  out  1  high in any state other than IDLE
lcd_rest_n  out  1  panel reset, active low
lcd_cs_n  out  1  chip select
lcd_rs  out  1  register select
lcd_wr_n  out  1  write strobe; data latched by panel on rising edge
lcd_rd_n  out  1  constant 1
lcd_data  out  8  bus data

Behaviour:
- Reset values: lcd_rest_n=0, lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_data=0, s_ready=0, init_done=0, busy=1. State=RST_LOW. All pin outputs registered.
- States: RST_LOW -> RST_WAIT -> IDLE -> SETUP -> WR_LO <-> WR_HI -> IDLE.
- RST_LOW: lcd_rest_n=0 for exactly RST_LOW_CYC cycles; then RST_WAIT: lcd_rest_n=1 for RST_WAIT_CYC cycles; then IDLE with init_done=1 (held until next reset sequence).
- IDLE: s_ready=1, lcd_cs_n=1, lcd_wr_n=1. Accept -> SETUP next cycle.
- SETUP (1 cycle): lcd_cs_n=0, lcd_rs=s_rs, lcd_data=first byte (s_data[15:8] if wide else [7:0]), lcd_wr_n=1.
- WR_LO: lcd_wr_n=0 for WR_LOW_CYC cycles; data/rs stable.
- WR_HI: lcd_wr_n=1 for WR_HIGH_CYC cycles; data/rs held through entire phase (hold time).
- End of WR_HI: if second byte of a wide beat pending -> WR_LO with lcd_data=s_data[7:0]; else if new beat accepted -> WR_LO with new rs/first byte (cs_n stays low, no SETUP); else -> IDLE, cs_n=1.
- s_ready also 1 in final WR_HI cycle when no second byte pending (back-to-back streaming). s_ready=0 in all other states, and 0 whenever a hw_reset_req is pending.
- Streaming byte period = WR_LOW_CYC+WR_HIGH_CYC cycles; wide beat = 2 periods.
- hw_reset_req: latched into a pending flag. Serviced on entry to/while in IDLE: -> RST_LOW, init_done=0. Pulse during transfer never truncates the current beat; current beat completes first. Request during RST_LOW/RST_WAIT is ignored (cleared).
- Async reset mid-transfer: immediate return to reset values; partial beat discarded.
- Counters: single down-counter, width $clog2(max(all four params)+1), loaded on state entry with param-1.

Decomposition:
- Package lcd_8080_pkg: state enum (RST_LOW, RST_WAIT, IDLE, SETUP, WR_LO, WR_HI), default timing constants, byte-select helper.
- One natural sub-module: lcd_phase_timer (loadable down-counter with done flag) shared by reset and strobe phases.

Test Plan:
- Sim params RST_LOW_CYC=4, RST_WAIT_CYC=8: deassert reset -> lcd_rest_n low 4 cycles, high; init_done rises 8 cycles later; s_ready=0 until then.
- Narrow command s_data=0x002C, s_rs=0, s_wide=0 -> SETUP with data=0x2C, rs=0, wr_n low 2 cycles, high 2, cs_n=1 next cycle.
- Wide pixel 0xF800, s_rs=1 -> bytes 0xF8 then 0x00, two WR_n pulses, cs_n low continuously, rs=1 throughout.
- Three back-to-back wide pixels with s_valid held -> six WR_n rising edges exactly 4 cycles apart, no cs_n gap.
- hw_reset_req pulsed mid-WR_LO of wide beat -> both bytes complete, cs_n=1, then lcd_rest_n=0 for 4 cycles, init_done=0 until sequence ends.
- Async reset asserted during WR_LO -> same edge: wr_n=1, cs_n=1, lcd_rest_n=0, s_ready=0.
